// File: rtl/digit_scan_if.sv
// Bus between the scan controller and its user.
//   en          : scan enable (master -> slave)
//   data        : eight display nibbles, digit i = data[4i+3:4i]
//   digit_mask  : per-digit light enable
//   a, cs       : 3-to-8 decoder select / enable (slave -> master)
//   nibble      : value of the selected digit
//   frame_start : one-cycle pulse at the first cycle of slot 0
interface digit_scan_if;
    logic        en;
    logic [31:0] data;
    logic [7:0]  digit_mask;
    logic [2:0]  a;
    logic [2:0]  cs;
    logic [3:0]  nibble;
    logic        frame_start;

    modport master (
        output en, data, digit_mask,
        input  a, cs, nibble, frame_start
    );

    modport slave (
        input  en, data, digit_mask,
        output a, cs, nibble, frame_start
    );
endinterface

// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit seven-segment board.
// Steps a digit index every DIV cycles, blanks the decoder for the first
// BLANK cycles of each slot, and latches display data once per frame.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : digit_scan_if slave (en/data/digit_mask in; a/cs/nibble/frame_start out)
// Outputs are decoded from registers only, so asserting rst_n blanks the
// display immediately without waiting for a clock edge.
module digit_scan_ctrl #(
    parameter int unsigned DIV   = 100000,
    parameter int unsigned BLANK = 1000
) (
    input  logic         clk,
    input  logic         rst_n,
    digit_scan_if.slave  bus
);

    localparam int unsigned CW = $clog2(DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [31:0]   shadow_data_q;
    logic [7:0]    shadow_mask_q;
    logic          load;
    logic          running;
    logic          lit;

    // State and shadow registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            shadow_data_q <= '0;
            shadow_mask_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            if (load) begin
                shadow_data_q <= bus.data;
                shadow_mask_q <= bus.digit_mask;
            end
        end
    end

    // Next-state: stop, start, or advance the slot counter / digit index
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        load    = 1'b0;

        if (!bus.en) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    idx_d   = '0;
                    load    = 1'b1;
                end
                S_RUN: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        idx_d = idx_q + 3'd1;
                        // Reload shadows only on the 7->0 wrap: frame-atomic update
                        load  = (idx_q == 3'd7);
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // Anti-ghosting window; with BLANK=0 every cycle of the slot is lit
    generate
        if (BLANK == 0) begin : g_no_blank
            assign lit = 1'b1;
        end else begin : g_blank
            assign lit = (cnt_q >= CW'(BLANK));
        end
    endgenerate

    assign running         = (state_q == S_RUN);
    assign bus.a           = idx_q;
    assign bus.nibble      = shadow_data_q[{idx_q, 2'b00} +: 4];
    assign bus.cs          = (running && lit && shadow_mask_q[idx_q]) ? 3'b110 : 3'b000;
    assign bus.frame_start = running && (idx_q == 3'd0) && (cnt_q == '0);

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Scoreboard bench for digit_scan_ctrl: two instances (DIV=4/BLANK=1 and
// DIV=2/BLANK=0) share one stimulus stream; a cycle-count model predicts
// each instance's outputs and queues them for comparison after the edge.
module tb_digit_scan_ctrl;

    typedef struct packed {
        logic [2:0] a;
        logic [2:0] cs;
        logic [3:0] nib;
        logic       fs;
    } out_t;

    logic clk;
    logic rst_n;

    digit_scan_if bus4 ();
    digit_scan_if bus2 ();

    digit_scan_ctrl #(.DIV(4), .BLANK(1)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    digit_scan_ctrl #(.DIV(2), .BLANK(0)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    int unsigned divs   [2] = '{4, 2};
    int unsigned blanks [2] = '{1, 0};
    bit          m_run  [2];
    int unsigned m_t    [2];
    logic [31:0] m_sd   [2];
    logic [7:0]  m_sm   [2];

    out_t exp4_q[$];
    out_t exp2_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Model: position in the frame is simply the cycle count since Start
    function automatic out_t model_out(input int k);
        out_t        o;
        int unsigned idx;
        int unsigned cnt;
        idx   = m_run[k] ? (m_t[k] / divs[k]) % 8 : 0;
        cnt   = m_run[k] ? (m_t[k] % divs[k]) : 0;
        o.a   = 3'(idx);
        o.nib = m_sd[k][4*idx +: 4];
        o.cs  = (m_run[k] && cnt >= blanks[k] && m_sm[k][idx]) ? 3'b110 : 3'b000;
        o.fs  = m_run[k] && ((m_t[k] % (8 * divs[k])) == 0);
        return o;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_run[k] = 1'b0;
            m_t[k]   = 0;
            m_sd[k]  = '0;
            m_sm[k]  = '0;
        end
    endtask

    task automatic model_step(input logic en, input logic [31:0] d, input logic [7:0] m);
        for (int k = 0; k < 2; k++) begin
            if (!en) begin
                m_run[k] = 1'b0;
                m_t[k]   = 0;
            end else if (!m_run[k]) begin
                m_run[k] = 1'b1;
                m_t[k]   = 0;
                m_sd[k]  = d;
                m_sm[k]  = m;
            end else begin
                m_t[k] = m_t[k] + 1;
                if ((m_t[k] % (8 * divs[k])) == 0) begin
                    m_sd[k] = d;
                    m_sm[k] = m;
                end
            end
        end
    endtask

    task automatic cmp_out(input string inst, input out_t got, input out_t exp);
        chk({inst, "_a"},  32'(got.a),   32'(exp.a));
        chk({inst, "_cs"}, 32'(got.cs),  32'(exp.cs));
        chk({inst, "_nib"}, 32'(got.nib), 32'(exp.nib));
        chk({inst, "_fs"}, 32'(got.fs),  32'(exp.fs));
    endtask

    // One clock: drive inputs, queue predictions, compare just after the edge
    task automatic step(input logic en, input logic [31:0] d, input logic [7:0] m);
        out_t got;
        bus4.en = en; bus4.data = d; bus4.digit_mask = m;
        bus2.en = en; bus2.data = d; bus2.digit_mask = m;
        model_step(en, d, m);
        exp4_q.push_back(model_out(0));
        exp2_q.push_back(model_out(1));
        @(posedge clk);
        #1;
        got = '{a: bus4.a, cs: bus4.cs, nib: bus4.nibble, fs: bus4.frame_start};
        cmp_out("d4", got, exp4_q.pop_front());
        got = '{a: bus2.a, cs: bus2.cs, nib: bus2.nibble, fs: bus2.frame_start};
        cmp_out("d2", got, exp2_q.pop_front());
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_a4"},  32'(bus4.a), 0);
        chk({tag, "_cs4"}, 32'(bus4.cs), 0);
        chk({tag, "_nib4"}, 32'(bus4.nibble), 0);
        chk({tag, "_fs4"}, 32'(bus4.frame_start), 0);
        chk({tag, "_a2"},  32'(bus2.a), 0);
        chk({tag, "_cs2"}, 32'(bus2.cs), 0);
        chk({tag, "_nib2"}, 32'(bus2.nibble), 0);
        chk({tag, "_fs2"}, 32'(bus2.frame_start), 0);
    endtask

    logic [31:0] d_cur;
    logic [7:0]  m_cur;

    initial begin
        rst_n = 1'b1;
        bus4.en = 1'b0; bus4.data = '0; bus4.digit_mask = '0;
        bus2.en = 1'b0; bus2.data = '0; bus2.digit_mask = '0;
        model_reset();
        #2 rst_n = 1'b0;
        #1 chk_all_zero("rst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic scan
        d_cur = 32'h7654_3210;
        m_cur = 8'hFF;
        step(1'b1, d_cur, m_cur);
        chk("start_fs", 32'(bus4.frame_start), 1);
        chk("start_cs_blank", 32'(bus4.cs), 0);
        for (int i = 0; i < 39; i++) step(1'b1, d_cur, m_cur);

        // Frame-atomic update: change data while digit 3 is displayed
        for (int i = 0; i < 64 && ((m_t[0] / 4) % 8) != 3; i++) step(1'b1, d_cur, m_cur);
        chk("wait_idx3", 32'((m_t[0] / 4) % 8), 3);
        d_cur = 32'hFEDC_BA98;
        step(1'b1, d_cur, m_cur);
        chk("atomic_nib3", 32'(bus4.nibble), 3);
        for (int i = 0; i < 40; i++) step(1'b1, d_cur, m_cur);

        // Masking
        m_cur = 8'b1010_0101;
        for (int i = 0; i < 72; i++) step(1'b1, d_cur, m_cur);

        // Stop at idx=5, cnt=2 on the DIV=4 instance, then restart
        for (int i = 0; i < 64 && (m_t[0] % 32) != 22; i++) step(1'b1, d_cur, m_cur);
        chk("wait_stop", 32'(m_t[0] % 32), 22);
        step(1'b0, d_cur, m_cur);
        chk("stop_a", 32'(bus4.a), 0);
        chk("stop_cs", 32'(bus4.cs), 0);
        for (int i = 0; i < 3; i++) step(1'b0, d_cur, m_cur);
        d_cur = 32'h1357_9BDF;
        m_cur = 8'hFF;
        step(1'b1, d_cur, m_cur);
        chk("restart_fs", 32'(bus4.frame_start), 1);
        chk("restart_nib", 32'(bus4.nibble), 32'hF);
        for (int i = 0; i < 21; i++) step(1'b1, d_cur, m_cur);

        // Asynchronous reset mid-slot
        #3 rst_n = 1'b0;
        #1 chk_all_zero("rst_mid");
        bus4.en = 1'b0; bus2.en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1 chk_all_zero("rst_hold");
        end
        model_reset();
        rst_n = 1'b1;

        // Continuous drive with BLANK=0 on the DIV=2 instance
        d_cur = 32'h0F1E_2D3C;
        m_cur = 8'hFF;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, d_cur, m_cur);
            chk("b0_cs", 32'(bus2.cs), 32'h6);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout @%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
